bcd_updown_counter: RTL
=======================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter, the successor to the single-digit 0-9 BCD counter. It counts in packed BCD across `DIGITS` decade stages, with count enable, direction control, synchronous parallel load with BCD validity checking, and a registered wrap (carry/borrow) pulse. It is used as a decimal event/time counter and cascades into wider counters through `wrap`.

## Interface
- `DIGITS`, default 4: number of BCD decades. Legal range is 1-8.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset. It clears all state immediately, independent of `clk`.
- `en` input 1: count enable; when high, the counter advances one step per cycle.
- `up` input 1: direction; 1 counts up, 0 counts down. Sampled only when counting.
- `load` input 1: synchronous parallel load request.
- `load_val` input 4*DIGITS: packed BCD load value; digit 0 sits in bits [3:0].
- `count` output 4*DIGITS: packed BCD count; digit 0 is the least significant decade, in bits [3:0].
- `wrap` output 1: one-cycle pulse marking a full-range wrap (carry when counting up, borrow when counting down).
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- Reset values: `count` = 0 (all digits 0), `wrap` = 0, `load_err` = 0.
- Per-edge priority: `load` > `en` > hold.
- Load path:
  - When `load`=1 and every nibble of `load_val` is ≤ 9: `count` <= `load_val`, `load_err` <= 0.
  - When `load`=1 and any nibble is > 9: `count` holds its value (the whole word is rejected, no partial load) and `load_err` <= 1.
  - `wrap` <= 0 on any load cycle. `en` and `up` are ignored while `load`=1.
- Count up (`en`=1, `up`=1, `load`=0):
  - Digit i increments when all lower digits equal 9.
  - A digit that is at 9 and receives an increment becomes 0.
  - All digits at 9 → all 0, and `wrap` <= 1.
- Count down (`en`=1, `up`=0, `load`=0):
  - Digit i decrements when all lower digits equal 0.
  - A digit that is at 0 and receives a decrement becomes 9.
  - All digits at 0 → all 9, and `wrap` <= 1.
- Hold (`en`=0, `load`=0): `count` is unchanged; `wrap` <= 0, `load_err` <= 0.
- Invariant: every nibble of `count` is always in 0-9. No out-of-range state is reachable from reset.
- Ripple: the carry/borrow chain is combinational across the digits within one cycle. There are no per-digit pipeline stages.

## Timing
- `count`, `wrap` and `load_err` are all registered outputs. None has a combinational path from any input.
- Count latency: `count` reflects a step one edge after `en` is sampled high.
- Wrap timing: `wrap` is high in exactly the cycle in which `count` first shows the wrapped value (0…0 after counting up, 9…9 after counting down). It is low in the following cycle unless another wrap occurs; with `DIGITS`=1, a wrap can recur every 10 cycles.
- Load timing: the loaded value is visible one edge after `load` is sampled. `load_err` is high for exactly one cycle per rejected load edge.
- Direction changes: a change of `up` takes effect on the next enabled edge. There are no dead cycles.
- Reset mid-operation: asserting `rst` forces the reset values without waiting for a clock edge, even mid-count or mid-load. After `rst` deasserts, the first enabled edge steps from 0.
- Simultaneous `load` and `en`: the load wins; no count step occurs on that edge.

## Test plan
- Reset and hold:
  - Stimulus: `DIGITS`=2; assert `rst` asynchronously between clock edges while `count`=37.
  - Required response: `count`=00, `wrap`=0, `load_err`=0 immediately.
  - Then, with `en`=0 for 5 cycles, `count` stays 00.
- Up count and carry:
  - Stimulus: `DIGITS`=2, `en`=1, `up`=1, starting at 00, for 105 cycles.
  - Required response: `count` goes 00→01…→09→10 (digit 1 increments on the 9→0 of digit 0)…→99→00.
  - `wrap` is high only in the cycle where `count`=00 after 99 (cycle 100).
- Down count and borrow:
  - Stimulus: load 10, then `en`=1, `up`=0.
  - Required response: `count` goes 10→09→…→00→99; `wrap`=1 in the cycle showing 99, and `wrap`=0 otherwise.
- Load validity:
  - Stimulus: `load`=1 with `load_val`=0x42.
  - Required response: `count`=42 next cycle, `load_err`=0.
  - Stimulus: `load_val`=0x4A (low nibble > 9).
  - Required response: `count` stays 42, `load_err`=1 for one cycle.
  - Stimulus: `load`=1 and `en`=1 together with 0x55.
  - Required response: `count`=55, not 56.
- Direction flip at boundary:
  - Stimulus: at `count`=99 with `up`=1, step once, then set `up`=0 and step once.
  - Required response: `count` goes 99→00 with `wrap`=1, then 00→99 with `wrap`=1. These are two consecutive wrap cycles.
- Width scaling:
  - Stimulus: `DIGITS`=4, load 9998, `en`=1, `up`=1, for 3 cycles.
  - Required response: `count` goes 9999 → 0000 (`wrap`=1) → 0001.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit packed-BCD up/down counter with count enable, direction
// control, synchronous parallel load (with BCD validity check) and a
// registered full-range wrap pulse for cascading.
//
// Parameters:
//   DIGITS    number of BCD decades (1..8)
//
// Ports:
//   clk       clock, rising-edge active
//   rst       asynchronous active-high reset
//   en        count enable (one step per cycle)
//   up        direction: 1 = up, 0 = down
//   load      synchronous parallel load request (wins over en)
//   load_val  packed BCD load value, digit 0 in [3:0]
//   count     packed BCD count, digit 0 in [3:0] (registered)
//   wrap      one-cycle carry/borrow pulse on full-range wrap (registered)
//   load_err  one-cycle pulse when a load contains a nibble > 9 (registered)
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_reg;
    logic [4*DIGITS-1:0] count_next;
    logic                wrap_reg;
    logic                load_err_reg;

    // carry_chain[i]: all digits below i are 9 (digit i receives an increment).
    // borrow_chain[i]: all digits below i are 0 (digit i receives a decrement).
    // Index DIGITS therefore flags a full-range wrap.
    logic [DIGITS:0]     carry_chain;
    logic [DIGITS:0]     borrow_chain;
    logic [DIGITS-1:0]   nib_ok;

    assign carry_chain[0]  = 1'b1;
    assign borrow_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            logic [3:0] digit_next;

            assign digit = count_reg[4*gi +: 4];

            assign carry_chain[gi+1]  = carry_chain[gi]  & (digit == 4'd9);
            assign borrow_chain[gi+1] = borrow_chain[gi] & (digit == 4'd0);

            assign nib_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);

            always_comb begin
                digit_next = digit;
                if (up) begin
                    if (carry_chain[gi])
                        digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                end else begin
                    if (borrow_chain[gi])
                        digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                end
            end

            assign count_next[4*gi +: 4] = digit_next;
        end
    endgenerate

    logic wrap_next;
    assign wrap_next = up ? carry_chain[DIGITS] : borrow_chain[DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else if (load) begin
            // Whole-word reject: a single bad nibble leaves count untouched.
            if (&nib_ok) begin
                count_reg    <= load_val;
                load_err_reg <= 1'b0;
            end else begin
                load_err_reg <= 1'b1;
            end
            wrap_reg <= 1'b0;
        end else if (en) begin
            count_reg    <= count_next;
            wrap_reg     <= wrap_next;
            load_err_reg <= 1'b0;
        end else begin
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end
    end

    assign count    = count_reg;
    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;

endmodule
